// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS core: opcode/funct values,
// reset PC default, and the ALU-op and next-PC-select enums.
package mips_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_OR,
        ALU_LUI,
        ALU_SLL
    } alu_op_e;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_BEQ,
        NPC_JUMP,
        NPC_JR
    } npc_sel_e;

    typedef enum logic [1:0] {
        WD_ALU,
        WD_MEM,
        WD_LINK
    } wd_sel_e;

endpackage

// File: rtl/mips_grf.sv
// 32x32 general-purpose register file: two combinational read ports, one
// write port committed on the rising edge; $0 is hard-wired to zero.
module mips_grf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs_q[wa] <= wd;
        end
    end

    // Reads see the pre-edge value, so a same-cycle write is not forwarded.
    assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs_q[ra2];

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS core with internal instruction ROM and data RAM.
// Define TRACE_DISPLAY_EN to print a line for every committed GPR/DM write.
module mips_cpu
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_WORDS = 4096,
    parameter int          DM_WORDS = 3072
) (
    input logic clk,
    input logic reset
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] pc_off;
    logic [11:0] im_idx;
    logic [31:0] instr;

    logic [31:0] im_mem [IM_WORDS];
    logic [31:0] dm_q   [DM_WORDS];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    alu_op_e     alu_op;
    npc_sel_e    npc_sel;
    wd_sel_e     wd_sel;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic        dm_we;
    logic        alu_b_sext;
    logic        alu_b_zext;

    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [31:0] rf_wd;
    logic [11:0] dm_idx;
    logic        dm_in_range;
    logic [31:0] dm_rdata;

    // Fetch: the ROM is word-indexed relative to the reset PC.
    assign pc_off   = pc_q - PC_RESET;
    assign im_idx   = pc_off[13:2];
    assign instr    = (int'(im_idx) < IM_WORDS) ? im_mem[im_idx] : 32'h0;
    assign pc_plus4 = pc_q + 32'd4;

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm16    = instr[15:0];
    assign imm26    = instr[25:0];
    assign imm_sext = {{16{imm16[15]}}, imm16};
    assign imm_zext = {16'h0, imm16};

    // Decode; anything not listed falls through to the nop defaults.
    always_comb begin
        alu_op     = ALU_ADD;
        npc_sel    = NPC_SEQ;
        wd_sel     = WD_ALU;
        rf_we      = 1'b0;
        rf_wa      = rd;
        dm_we      = 1'b0;
        alu_b_sext = 1'b0;
        alu_b_zext = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin
                        alu_op = ALU_ADD;
                        rf_we  = 1'b1;
                    end
                    FN_SUBU: begin
                        alu_op = ALU_SUB;
                        rf_we  = 1'b1;
                    end
                    FN_SLL: begin
                        alu_op = ALU_SLL;
                        rf_we  = 1'b1;
                    end
                    FN_JR: begin
                        npc_sel = NPC_JR;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                alu_op     = ALU_OR;
                alu_b_zext = 1'b1;
                rf_we      = 1'b1;
                rf_wa      = rt;
            end
            OP_LUI: begin
                alu_op = ALU_LUI;
                rf_we  = 1'b1;
                rf_wa  = rt;
            end
            OP_LW: begin
                alu_b_sext = 1'b1;
                wd_sel     = WD_MEM;
                rf_we      = 1'b1;
                rf_wa      = rt;
            end
            OP_SW: begin
                alu_b_sext = 1'b1;
                dm_we      = 1'b1;
            end
            OP_BEQ: begin
                npc_sel = NPC_BEQ;
            end
            OP_J: begin
                npc_sel = NPC_JUMP;
            end
            OP_JAL: begin
                npc_sel = NPC_JUMP;
                wd_sel  = WD_LINK;
                rf_we   = 1'b1;
                rf_wa   = 5'd31;
            end
            default: ;
        endcase
    end

    mips_grf u_grf (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (rf_we),
        .wa    (rf_wa),
        .wd    (rf_wd)
    );

    always_comb begin
        alu_b = rd2;
        if (alu_b_sext) begin
            alu_b = imm_sext;
        end else if (alu_b_zext) begin
            alu_b = imm_zext;
        end
    end

    always_comb begin
        alu_y = 32'h0;
        case (alu_op)
            ALU_ADD: alu_y = rd1 + alu_b;
            ALU_SUB: alu_y = rd1 - alu_b;
            ALU_OR:  alu_y = rd1 | alu_b;
            ALU_LUI: alu_y = {imm16, 16'h0};
            ALU_SLL: alu_y = rd2 << shamt;
            default: alu_y = 32'h0;
        endcase
    end

    // Data RAM: word access only; addresses past the array read 0, drop writes.
    assign dm_idx      = alu_y[13:2];
    assign dm_in_range = int'(dm_idx) < DM_WORDS;
    assign dm_rdata    = dm_in_range ? dm_q[dm_idx] : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm_q[i] <= 32'h0;
            end
        end else if (dm_we && dm_in_range) begin
            dm_q[dm_idx] <= rd2;
        end
    end

    always_comb begin
        rf_wd = alu_y;
        case (wd_sel)
            WD_MEM:  rf_wd = dm_rdata;
            WD_LINK: rf_wd = pc_plus4;
            default: rf_wd = alu_y;
        endcase
    end

    always_comb begin
        pc_d = pc_plus4;
        case (npc_sel)
            NPC_BEQ: begin
                if (rd1 == rd2) begin
                    pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
                end
            end
            NPC_JUMP: pc_d = {pc_plus4[31:28], imm26, 2'b00};
            NPC_JR:   pc_d = rd1;
            default:  pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef TRACE_DISPLAY_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (rf_we && (rf_wa != 5'd0)) begin
                $display("@%h: $%d <= %h", pc_q, rf_wa, rf_wd);
            end
            if (dm_we) begin
                $display("@%h: *%h <= %h", pc_q, alu_y, rd2);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: preloads a short program into the ROM and
// checks PC, GPR and DM state after each instruction with immediate assertions.
module tb_mips_cpu;

    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    mips_cpu dut (
        .clk   (clk),
        .reset (reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step(input string name, input logic [31:0] pc_before);
        check({name, "_pc_before"}, dut.pc_q, pc_before);
        @(posedge clk);
        @(negedge clk);
        $display("step %s at pc=%h -> pc=%h", name, pc_before, dut.pc_q);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 64; i++) begin
            dut.im_mem[i] = 32'h0;
        end
        dut.im_mem[0]  = 32'h3401_1234; // 3000 ori  $1,$0,0x1234
        dut.im_mem[1]  = 32'h3C02_ABCD; // 3004 lui  $2,0xABCD
        dut.im_mem[2]  = 32'h0022_1821; // 3008 addu $3,$1,$2
        dut.im_mem[3]  = 32'h0001_2023; // 300C subu $4,$0,$1
        dut.im_mem[4]  = 32'h1000_0002; // 3010 beq  $0,$0,+2
        dut.im_mem[5]  = 32'h3406_DEAD; // 3014 skipped
        dut.im_mem[6]  = 32'h3406_BEEF; // 3018 skipped
        dut.im_mem[7]  = 32'h1020_0005; // 301C beq  $1,$0,+5 (not taken)
        dut.im_mem[8]  = 32'h0C00_0C10; // 3020 jal  0x3040
        dut.im_mem[9]  = 32'hAC03_0008; // 3024 sw   $3,8($0)
        dut.im_mem[10] = 32'h8C05_0008; // 3028 lw   $5,8($0)
        dut.im_mem[11] = 32'h3407_000C; // 302C ori  $7,$0,12
        dut.im_mem[12] = 32'hACE4_FFFC; // 3030 sw   $4,-4($7)
        dut.im_mem[13] = 32'h3400_0005; // 3034 ori  $0,$0,5
        dut.im_mem[14] = 32'h0001_4100; // 3038 sll  $8,$1,4
        dut.im_mem[15] = 32'hFFFF_FFFF; // 303C unsupported -> nop
        dut.im_mem[16] = 32'h03E0_0008; // 3040 jr   $31

        #10;
        check("reset_pc", dut.pc_q, 32'h0000_3000);
        check("reset_fetch", dut.instr, 32'h3401_1234);
        for (int r = 1; r < 32; r++) begin
            check($sformatf("reset_gpr%0d", r), dut.u_grf.regs_q[r], 32'h0);
        end
        reset = 1'b0;

        step("ori", 32'h0000_3000);
        check("ori_r1", dut.u_grf.regs_q[1], 32'h0000_1234);
        step("lui", 32'h0000_3004);
        check("lui_r2", dut.u_grf.regs_q[2], 32'hABCD_0000);
        step("addu", 32'h0000_3008);
        check("addu_r3", dut.u_grf.regs_q[3], 32'hABCD_1234);
        step("subu", 32'h0000_300C);
        check("subu_r4", dut.u_grf.regs_q[4], 32'hFFFF_EDCC);
        step("beq_taken", 32'h0000_3010);
        check("beq_taken_pc", dut.pc_q, 32'h0000_301C);
        step("beq_not_taken", 32'h0000_301C);
        check("beq_not_taken_pc", dut.pc_q, 32'h0000_3020);
        check("beq_skip_r6", dut.u_grf.regs_q[6], 32'h0);
        step("jal", 32'h0000_3020);
        check("jal_r31", dut.u_grf.regs_q[31], 32'h0000_3024);
        check("jal_pc", dut.pc_q, 32'h0000_3040);
        step("jr", 32'h0000_3040);
        check("jr_pc", dut.pc_q, 32'h0000_3024);
        step("sw", 32'h0000_3024);
        check("sw_dm2", dut.dm_q[2], 32'hABCD_1234);
        step("lw", 32'h0000_3028);
        check("lw_r5", dut.u_grf.regs_q[5], 32'hABCD_1234);
        step("ori_base", 32'h0000_302C);
        check("ori_r7", dut.u_grf.regs_q[7], 32'h0000_000C);
        step("sw_negoff", 32'h0000_3030);
        check("sw_negoff_dm2", dut.dm_q[2], 32'hFFFF_EDCC);
        check("sw_negoff_dm3", dut.dm_q[3], 32'h0);
        step("ori_r0", 32'h0000_3034);
        check("ori_r0_stays0", dut.u_grf.regs_q[0], 32'h0);
        check("ori_r0_readport", dut.u_grf.rd1, 32'h0);
        step("sll", 32'h0000_3038);
        check("sll_r8", dut.u_grf.regs_q[8], 32'h0001_2340);
        step("unsupported", 32'h0000_303C);
        check("unsupported_pc", dut.pc_q, 32'h0000_3040);
        check("unsupported_r31", dut.u_grf.regs_q[31], 32'h0000_3024);

        // Asynchronous reset in the middle of execution.
        reset = 1'b1;
        #1;
        check("midreset_pc", dut.pc_q, 32'h0000_3000);
        check("midreset_r1", dut.u_grf.regs_q[1], 32'h0);
        check("midreset_r31", dut.u_grf.regs_q[31], 32'h0);
        check("midreset_dm2", dut.dm_q[2], 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("midreset_hold_pc", dut.pc_q, 32'h0000_3000);
        check("midreset_hold_r1", dut.u_grf.regs_q[1], 32'h0);
        reset = 1'b0;
        step("restart_ori", 32'h0000_3000);
        check("restart_r1", dut.u_grf.regs_q[1], 32'h0000_1234);
        check("restart_pc", dut.pc_q, 32'h0000_3004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
